rt_counter_ctrl: RTL and testbench

RT_COUNTER_CTRL -- requirements
Module: rt_counter_ctrl

---
 rtl/rt_counter_ctrl.sv | 154 +++++++++++++++
 tb/tb_rt_counter_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_counter_ctrl.sv
// Run/stop/clear/set controller for an external mod-N counter.
// Generates the count tick from a clock prescaler and drives load/enable strobes.
module rt_counter_ctrl #(
  parameter int  CLK_HZ  = 100_000_000,
  parameter int  TICK_HZ = 1,
  parameter int  N       = 60,
  localparam int DIV     = CLK_HZ / TICK_HZ,
  localparam int WIDTH   = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             clear_btn,
  input  logic             set_btn,
  input  logic [WIDTH-1:0] set_value,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_data,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam int PW = $clog2(DIV);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("rt_counter_ctrl: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (N < 2) begin : g_n_chk
      $error("rt_counter_ctrl: N must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    LOAD   = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_SET,
    CMD_STOP,
    CMD_CLEAR
  } cmd_t;

  localparam int B_START = 0;
  localparam int B_SET   = 1;
  localparam int B_STOP  = 2;
  localparam int B_CLR   = 3;

  logic [3:0]       btn;
  logic [3:0]       btn_q;
  logic [3:0]       armed;
  logic [3:0]       btn_edge;
  cmd_t             cmd;
  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [WIDTH-1:0] set_sat;

  assign btn = {clear_btn, stop_btn, set_btn, start_btn};

  // A command held high across reset stays disarmed until it is seen low,
  // so releasing reset never manufactures an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= '0;
      armed <= ~btn;
    end else begin
      btn_q <= btn;
      armed <= armed | ~btn;
    end
  end

  assign btn_edge = btn & ~btn_q & armed;

  always_comb begin
    cmd = CMD_NONE;
    if      (btn_edge[B_CLR])   cmd = CMD_CLEAR;
    else if (btn_edge[B_STOP])  cmd = CMD_STOP;
    else if (btn_edge[B_SET])   cmd = CMD_SET;
    else if (btn_edge[B_START]) cmd = CMD_START;
  end

  assign set_sat = (32'(set_value) >= N) ? WIDTH'(N - 1) : set_value;

  // Losing commands in the priority pick are dropped even when the winner
  // is ignored in the current state (e.g. stop+start while PAUSED).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      cnt_load      <= 1'b0;
      cnt_load_data <= '0;
    end else begin
      cnt_load <= 1'b0;
      if (cmd == CMD_CLEAR) begin
        state_q       <= IDLE;
        presc_q       <= '0;
        cnt_load      <= 1'b1;
        cnt_load_data <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd == CMD_START) begin
              state_q <= RUN;
              presc_q <= '0;
            end else if (cmd == CMD_SET) begin
              state_q       <= LOAD;
              cnt_load      <= 1'b1;
              cnt_load_data <= set_sat;
            end
          end
          RUN: begin
            // Stop freezes the prescaler at its current phase for resume.
            if (cmd != CMD_STOP) begin
              presc_q <= (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
            end else begin
              state_q <= PAUSED;
            end
          end
          PAUSED: begin
            if (cmd == CMD_START) begin
              state_q <= RUN;
            end else if (cmd == CMD_SET) begin
              state_q       <= LOAD;
              cnt_load      <= 1'b1;
              cnt_load_data <= set_sat;
            end
          end
          LOAD: begin
            state_q <= PAUSED;
            presc_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            presc_q <= '0;
          end
        endcase
      end
    end
  end

  assign tick   = (state_q == RUN) && (presc_q == PW'(DIV - 1));
  assign cnt_en = tick;
  assign wrap   = tick && (cnt_value == WIDTH'(N - 1));
  assign state  = state_q;

endmodule

// File: tb/tb_rt_counter_ctrl.sv
// Bench for rt_counter_ctrl (DIV=10, N=6): directed scenarios with literal
// expectations plus randomized commands checked each cycle against a model.
module tb_rt_counter_ctrl;
  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int N       = 6;
  localparam int DIV     = 10;
  localparam int W       = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_btn, stop_btn, clear_btn, set_btn;
  logic [W-1:0] set_value, cnt_value;
  logic         cnt_en, cnt_load, tick, wrap;
  logic [W-1:0] cnt_load_data;
  logic [1:0]   state;

  always #5 clk = ~clk;

  rt_counter_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N(N)) dut (
    .clk(clk), .reset(reset),
    .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .set_btn(set_btn),
    .set_value(set_value), .cnt_value(cnt_value),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_load_data(cnt_load_data),
    .tick(tick), .wrap(wrap), .state(state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 running, 2 paused, 3 loading; phase = cycles run mod DIV.
  int mode = 0;
  int phase = 0;
  int m_data = 0;
  bit m_load = 1'b0;
  bit m_prev[4];
  bit m_held[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Command order below is the priority order: clear, stop, set, start.
  task automatic model_step();
    bit b[4];
    int win;
    b = '{clear_btn, stop_btn, set_btn, start_btn};
    if (reset) begin
      mode = 0; phase = 0; m_load = 0; m_data = 0;
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = 0;
        m_held[i] = b[i];
      end
      return;
    end
    win = -1;
    for (int i = 0; i < 4; i++)
      if (win < 0 && b[i] && !m_prev[i] && !m_held[i]) win = i;
    for (int i = 0; i < 4; i++) begin
      if (!b[i]) m_held[i] = 0;
      m_prev[i] = b[i];
    end
    m_load = 0;
    if (win == 0) begin
      mode = 0; phase = 0; m_load = 1; m_data = 0;
    end else if (mode == 3) begin
      mode = 2; phase = 0;
    end else if (mode == 1) begin
      if (win == 1) mode = 2;
      else phase = (phase + 1) % DIV;
    end else if (win == 3) begin
      if (mode == 0) phase = 0;
      mode = 1;
    end else if (win == 2) begin
      mode = 3; m_load = 1;
      m_data = (int'(set_value) > N - 1) ? N - 1 : int'(set_value);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit et;
      et = (mode == 1) && (phase == DIV - 1);
      check("state", state, mode);
      check("tick", tick, et);
      check("cnt_en", cnt_en, et);
      check("wrap", wrap, et && (cnt_value == N - 1));
      check("cnt_load", cnt_load, m_load);
      check("cnt_load_data", cnt_load_data, m_data);
      check("load_en_excl", cnt_load & cnt_en, 0);
    end
  end

  task automatic next();
    @(negedge clk);
    #1 model_step();
    @(posedge clk);
    #1 cyc++;
  endtask

  int tickq[$];
  int t0, e, d, n_pt;

  initial begin
    reset = 1; start_btn = 0; stop_btn = 0; clear_btn = 0; set_btn = 0;
    set_value = 0; cnt_value = 0;
    next();
    chk_en = 1;
    next();
    #1 check("rst_state", state, 0);
    check("rst_load", cnt_load, 0);
    check("rst_data", cnt_load_data, 0);

    // Start at cycle 0: ticks at 10, 20, 30; wrap only with cnt_value=5 at a tick.
    reset = 0; start_btn = 1; t0 = cyc;
    next();
    start_btn = 0;
    #1 check("run_at_1", state, 1);
    for (int k = 1; k <= 35; k++) begin
      cnt_value = (k >= 29 && k <= 31) ? 3'd5 : ((k == 20) ? 3'd4 : 3'd0);
      #1;
      if (tick) tickq.push_back(cyc - t0);
      if (k == 20) check("wrap_cv4", wrap, 0);
      if (k == 29) check("wrap_pre", wrap, 0);
      if (k == 30) check("wrap_cv5", wrap, 1);
      if (k == 31) check("wrap_post", wrap, 0);
      next();
    end
    cnt_value = 0;
    check("tick_count", tickq.size(), 3);
    for (int i = 0; i < 3; i++)
      check("tick_at", (i < tickq.size()) ? tickq[i] : -1, 10 * (i + 1));

    // Stop 3 cycles after the tick at 40, pause 20, resume: tick 7 cycles after entry.
    while (cyc - t0 < 43) next();
    stop_btn = 1;
    next();
    stop_btn = 0;
    #1 check("paused", state, 2);
    n_pt = 0;
    repeat (20) begin
      #1 if (tick) n_pt++;
      next();
    end
    check("paused_ticks", n_pt, 0);
    start_btn = 1;
    next();
    start_btn = 0;
    e = cyc; d = -1;
    for (int i = 0; i < 20; i++) begin
      #1 if (tick) begin d = cyc - e; break; end
      next();
    end
    check("resume_gap", d, 7);

    // Set from PAUSED: saturating and in-range values.
    stop_btn = 1;
    next();
    stop_btn = 0;
    set_value = 3'd7; set_btn = 1;
    next();
    set_btn = 0;
    #1 check("load_state", state, 3);
    check("load_strobe", cnt_load, 1);
    check("load_sat", cnt_load_data, 5);
    next();
    #1 check("after_load", state, 2);
    check("load_low", cnt_load, 0);
    check("load_hold", cnt_load_data, 5);
    set_value = 3'd3; set_btn = 1;
    next();
    set_btn = 0;
    #1 check("load_3", cnt_load_data, 3);
    check("load_strobe2", cnt_load, 1);
    next();

    // Clear+start while running, then stop+start while paused.
    start_btn = 1;
    next();
    start_btn = 0;
    repeat (4) next();
    clear_btn = 1; start_btn = 1;
    next();
    clear_btn = 0; start_btn = 0;
    #1 check("clr_state", state, 0);
    check("clr_load", cnt_load, 1);
    check("clr_data", cnt_load_data, 0);
    check("clr_tick", tick, 0);
    next();
    #1 check("clr_load_end", cnt_load, 0);
    set_btn = 1;
    next();
    set_btn = 0;
    next();
    #1 check("to_paused", state, 2);
    stop_btn = 1; start_btn = 1;
    next();
    stop_btn = 0; start_btn = 0;
    #1 check("stop_beats_start", state, 2);
    next();

    // Reset mid-run with start held high.
    start_btn = 1;
    repeat (4) next();
    #1 check("run_pre_rst", state, 1);
    reset = 1;
    next();
    #1 check("rst_mid_state", state, 0);
    check("rst_mid_load", cnt_load, 0);
    check("rst_mid_data", cnt_load_data, 0);
    reset = 0;
    repeat (3) next();
    #1 check("held_no_run", state, 0);
    start_btn = 0;
    next();
    start_btn = 1;
    next();
    #1 check("rearm_run", state, 1);
    start_btn = 0;

    // Randomized command traffic.
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 6) start_btn = ~start_btn;
      if ($urandom_range(0, 99) < 4) stop_btn  = ~stop_btn;
      if ($urandom_range(0, 99) < 5) set_btn   = ~set_btn;
      if ($urandom_range(0, 99) < 2) clear_btn = ~clear_btn;
      set_value = 3'($urandom_range(0, 7));
      cnt_value = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
